// File: rtl/uart_rx_fifo_os_if.sv
// Read-side bus of the eUSCI UART receiver.
// Carries the FIFO pop/clear requests from the register file and the FIFO
// head, occupancy and sticky status back from the receiver.
//   master : register file side (drives rdEn, clrErr)
//   slave  : receiver side (drives rdData, rdValid, level, st*, rxErr)
interface uart_rx_fifo_os_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rdEn;
  logic              clrErr;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic [LVL_W-1:0]  level;
  logic              stPE;
  logic              stFE;
  logic              stOE;
  logic              stBRK;
  logic              rxErr;

  modport master (
    output rdEn, clrErr,
    input  rdData, rdValid, level, stPE, stFE, stOE, stBRK, rxErr
  );

  modport slave (
    input  rdEn, clrErr,
    output rdData, rdValid, level, stPE, stFE, stOE, stBRK, rxErr
  );
endinterface

// File: rtl/uart_rx_fifo_os.sv
// eUSCI UART receiver with OS-times oversampling, 3-sample majority voting,
// runtime data length (5..DATA_W bits) and a FIFO_DEPTH-entry receive FIFO.
// Ports:
//   MCLK, reset_n   clock, asynchronous active-low reset
//   swrst           synchronous soft reset (same effect as reset_n)
//   osTick          one-MCLK pulse at OS x baud
//   Rx              asynchronous serial line, idles high
//   cfg*            frame configuration, changed only while swrst = 1
//   rd              read-side bus (pop, clear, FIFO head, level, flags)
//   rxBusy          receive FSM is not idle
module uart_rx_fifo_os #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int OS         = 16
) (
  input  logic             MCLK,
  input  logic             reset_n,
  input  logic             swrst,
  input  logic             osTick,
  input  logic             Rx,
  input  logic [3:0]       cfgLen,
  input  logic             cfgPEN,
  input  logic             cfgPAR,
  input  logic             cfgMSB,
  input  logic             cfgSPB,
  input  logic             cfgRXEIE,
  input  logic             cfgBRKIE,
  uart_rx_fifo_os_if.slave rd,
  output logic             rxBusy
);
  localparam int TW = $clog2(OS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [TW-1:0] T_S0   = TW'(OS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OS/2);
  localparam logic [TW-1:0] T_S2   = TW'(OS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
  } state_t;

  // Line synchronizer and edge detect
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Receive FSM and frame accumulation
  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        samp_q, samp_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;
  logic              brk_q, brk_d;

  // FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     cnt_q, cnt_d;

  // Sticky status
  logic st_pe_q, st_pe_d;
  logic st_fe_q, st_fe_d;
  logic st_oe_q, st_oe_d;
  logic st_brk_q, st_brk_d;

  logic       rx_s;
  logic       rx_fall;
  logic       maj;
  logic       maj_tick;
  logic [3:0] idx;
  logic       done;
  logic       keep;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign rx_s     = sync2_q;
  assign rx_fall  = prev_q & ~rx_s;
  // Third sample is the live synchronized value; the first two are held.
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign maj_tick = osTick && (tick_q == T_S2);

  always_comb begin
    sync1_d = Rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    tick_d  = tick_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    idx     = cfgMSB ? (cfgLen - 4'd1 - bit_q) : bit_q;

    // The tick counter free-runs across bit boundaries; each state decides on
    // the majority tick of its own bit, so state changes land mid-bit and the
    // next bit's samples still fall at ticks OS/2-1..OS/2+1.
    if (osTick && (state_q != IDLE) && (state_q != DONE)) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
      if (tick_q == T_S0) samp_d[0] = rx_s;
      if (tick_q == T_S1) samp_d[1] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
          data_d  = '0;
          par_d   = 1'b0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
          brk_d   = 1'b1;
        end
      end
      START: begin
        if (maj_tick) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (maj_tick) begin
          for (int unsigned k = 0; k < unsigned'(DATA_W); k++)
            if (k == 32'(idx)) data_d[k] = maj;
          par_d = par_q ^ maj;
          brk_d = brk_q & ~maj;
          bit_d = bit_q + 4'd1;
          if (bit_q == cfgLen - 4'd1) state_d = cfgPEN ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (maj_tick) begin
          pe_d    = maj != (cfgPAR ? par_q : ~par_q);
          brk_d   = brk_q & ~maj;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (maj_tick) begin
          fe_d    = ~maj;
          brk_d   = brk_q & ~maj;
          state_d = cfgSPB ? STOP2 : DONE;
        end
      end
      STOP2: begin
        if (maj_tick) begin
          fe_d    = fe_q | ~maj;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (swrst) begin
      sync1_d = 1'b1;
      sync2_d = 1'b1;
      prev_d  = 1'b1;
      state_d = IDLE;
      tick_d  = '0;
      samp_d  = '0;
      bit_d   = '0;
      data_d  = '0;
      par_d   = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      brk_d   = 1'b0;
    end
  end

  assign done  = (state_q == DONE);
  assign keep  = (~(pe_q | fe_q) | cfgRXEIE) & (~brk_q | cfgBRKIE);
  assign full  = (cnt_q == FULL_LVL);
  assign empty = (cnt_q == '0);
  assign pop   = rd.rdEn & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = done & keep & (~full | pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;

    if (push) begin
      mem_d[wr_q] = data_q;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first so that a set in the same cycle wins.
    st_pe_d  = (st_pe_q  & ~rd.clrErr) | (done & pe_q);
    st_fe_d  = (st_fe_q  & ~rd.clrErr) | (done & fe_q);
    st_brk_d = (st_brk_q & ~rd.clrErr) | (done & brk_q);
    st_oe_d  = (st_oe_q  & ~rd.clrErr) | (done & keep & full & ~pop);

    if (swrst) begin
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
      st_pe_d  = 1'b0;
      st_fe_d  = 1'b0;
      st_brk_d = 1'b0;
      st_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      samp_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      st_pe_q  <= 1'b0;
      st_fe_q  <= 1'b0;
      st_oe_q  <= 1'b0;
      st_brk_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      samp_q   <= samp_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_q    <= par_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      st_pe_q  <= st_pe_d;
      st_fe_q  <= st_fe_d;
      st_oe_q  <= st_oe_d;
      st_brk_q <= st_brk_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge MCLK) begin
    mem_q <= mem_d;
  end

  assign rd.rdData  = empty ? '0 : mem_q[rd_q];
  assign rd.rdValid = ~empty;
  assign rd.level   = cnt_q;
  assign rd.stPE    = st_pe_q;
  assign rd.stFE    = st_fe_q;
  assign rd.stOE    = st_oe_q;
  assign rd.stBRK   = st_brk_q;
  assign rd.rxErr   = st_pe_q | st_fe_q | st_oe_q;
  assign rxBusy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo_os.sv
module tb_uart_rx_fifo_os;
  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int OS         = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CYC    = OS * TICK_DIV;

  logic       MCLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       swrst = 1'b0;
  logic       osTick = 1'b0;
  logic       Rx = 1'b1;
  logic [3:0] cfgLen = 4'd8;
  logic       cfgPEN = 1'b0;
  logic       cfgPAR = 1'b0;
  logic       cfgMSB = 1'b0;
  logic       cfgSPB = 1'b0;
  logic       cfgRXEIE = 1'b0;
  logic       cfgBRKIE = 1'b0;
  logic       rxBusy;

  int n_cmp = 0;
  int n_bad = 0;
  int div_cnt = 0;

  uart_rx_fifo_os_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

  uart_rx_fifo_os #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OS(OS)) dut (
    .MCLK(MCLK), .reset_n(reset_n), .swrst(swrst), .osTick(osTick), .Rx(Rx),
    .cfgLen(cfgLen), .cfgPEN(cfgPEN), .cfgPAR(cfgPAR), .cfgMSB(cfgMSB),
    .cfgSPB(cfgSPB), .cfgRXEIE(cfgRXEIE), .cfgBRKIE(cfgBRKIE),
    .rd(rd_if), .rxBusy(rxBusy)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    osTick  = (div_cnt == TICK_DIV - 1);
    div_cnt = (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] len;
    logic       pen, par, msb, spb, rxeie, brkie;
    logic [8:0] data;
    logic       pbit, stop1, stop2;
    logic [2:0] lvl;
    logic [8:0] exp_d;
    logic       pe, fe, brk;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [3:0] len, input logic pen, par, msb, spb, rxeie, brkie,
                              input logic [8:0] data, input logic pbit, stop1, stop2,
                              input logic [2:0] lvl, input logic [8:0] exp_d,
                              input logic pe, fe, brk);
    vec_t v;
    v.len = len; v.pen = pen; v.par = par; v.msb = msb; v.spb = spb;
    v.rxeie = rxeie; v.brkie = brkie; v.data = data; v.pbit = pbit;
    v.stop1 = stop1; v.stop2 = stop2; v.lvl = lvl; v.exp_d = exp_d;
    v.pe = pe; v.fe = fe; v.brk = brk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(posedge MCLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    #1 Rx = b;
    repeat (BIT_CYC) @(posedge MCLK);
  endtask

  // data is the intended rdData value; MSB-first sends bit len-1 first.
  task automatic send_frame(input logic [8:0] data, input int len, input logic msb, pen, pbit,
                            stop1, spb, stop2);
    send_bit(1'b0);
    for (int k = 0; k < len; k++) send_bit(msb ? data[len-1-k] : data[k]);
    if (pen) send_bit(pbit);
    send_bit(stop1);
    if (spb) send_bit(stop2);
    #1 Rx = 1'b1;
    repeat (BIT_CYC / 2) @(posedge MCLK);
  endtask

  task automatic apply_cfg(input logic [3:0] len, input logic pen, par, msb, spb, rxeie, brkie);
    @(posedge MCLK);
    #1 swrst = 1'b1;
    cfgLen = len; cfgPEN = pen; cfgPAR = par; cfgMSB = msb;
    cfgSPB = spb; cfgRXEIE = rxeie; cfgBRKIE = brkie;
    repeat (2) @(posedge MCLK);
    #1 swrst = 1'b0;
    settle();
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] exp_d, input logic [2:0] lvl_after);
    chk($sformatf("%s_data", tag), rd_if.rdData, exp_d);
    rd_if.rdEn = 1'b1;
    @(posedge MCLK);
    #1 rd_if.rdEn = 1'b0;
    chk($sformatf("%s_level", tag), rd_if.level, lvl_after);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk($sformatf("%s_rdData", tag), rd_if.rdData, 0);
    chk($sformatf("%s_rdValid", tag), rd_if.rdValid, 0);
    chk($sformatf("%s_level", tag), rd_if.level, 0);
    chk($sformatf("%s_flags", tag), {rd_if.stPE, rd_if.stFE, rd_if.stOE, rd_if.stBRK, rd_if.rxErr}, 0);
    chk($sformatf("%s_rxBusy", tag), rxBusy, 0);
  endtask

  // Pops exactly in the DONE cycle: the majority sample of the stop bit is the
  // (nbits*OS + OS/2 + 2)-th osTick after START is entered.
  task automatic pop_in_done(input int nbits);
    int n;
    int budget;
    n = 0;
    budget = 4 * BIT_CYC;
    while (!rxBusy && budget > 0) begin
      @(posedge MCLK);
      #1;
      budget--;
    end
    chk("done_pop_busy_seen", rxBusy, 1);
    if (rxBusy) begin
      while (n < nbits * OS + OS / 2 + 2) begin
        @(posedge MCLK);
        if (osTick) n++;
      end
      #1 rd_if.rdEn = 1'b1;
      @(posedge MCLK);
      #1 rd_if.rdEn = 1'b0;
    end
  endtask

  initial begin
    rd_if.rdEn   = 1'b0;
    rd_if.clrErr = 1'b0;

    //       len   pen  par  msb  spb  rxe  brk  data    pb   s1   s2   lvl  exp     pe   fe   brk
    vecs[0]  = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 9'h0A5, 1'b0,1'b1,1'b1, 3'd1, 9'h0A5, 1'b0,1'b0,1'b0);
    vecs[1]  = mk(4'd9, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 9'h1A3, 1'b1,1'b1,1'b1, 3'd1, 9'h1A3, 1'b0,1'b0,1'b0);
    vecs[2]  = mk(4'd9, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 9'h1A3, 1'b0,1'b1,1'b1, 3'd0, 9'h000, 1'b1,1'b0,1'b0);
    vecs[3]  = mk(4'd9, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0, 9'h1A3, 1'b0,1'b1,1'b1, 3'd1, 9'h1A3, 1'b1,1'b0,1'b0);
    vecs[4]  = mk(4'd7, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 9'h055, 1'b0,1'b1,1'b0, 3'd0, 9'h000, 1'b0,1'b1,1'b0);
    vecs[5]  = mk(4'd7, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 9'h055, 1'b0,1'b1,1'b0, 3'd1, 9'h055, 1'b0,1'b1,1'b0);
    vecs[6]  = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 9'h000, 1'b0,1'b0,1'b1, 3'd0, 9'h000, 1'b0,1'b1,1'b1);
    vecs[7]  = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 9'h000, 1'b0,1'b0,1'b1, 3'd1, 9'h000, 1'b0,1'b1,1'b1);
    vecs[8]  = mk(4'd5, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 9'h013, 1'b0,1'b1,1'b1, 3'd1, 9'h013, 1'b0,1'b0,1'b0);
    vecs[9]  = mk(4'd8, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 9'h000, 1'b1,1'b1,1'b1, 3'd1, 9'h000, 1'b0,1'b0,1'b0);
    vecs[10] = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 9'h000, 1'b0,1'b1,1'b1, 3'd1, 9'h000, 1'b0,1'b0,1'b0);
    vecs[11] = mk(4'd6, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 9'h02D, 1'b0,1'b0,1'b1, 3'd1, 9'h02D, 1'b1,1'b1,1'b0);
    vecs[12] = mk(4'd8, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 9'h0C4, 1'b0,1'b1,1'b1, 3'd1, 9'h0C4, 1'b0,1'b0,1'b0);
    vecs[13] = mk(4'd8, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 9'h03C, 1'b0,1'b1,1'b1, 3'd1, 9'h03C, 1'b0,1'b0,1'b0);

    // Reset state
    repeat (3) @(posedge MCLK);
    #1 chk_idle_outputs("in_reset");
    reset_n = 1'b1;
    repeat (4) @(posedge MCLK);
    #1 chk_idle_outputs("after_reset");

    // Table-driven single frames
    for (int i = 0; i < 14; i++) begin
      apply_cfg(vecs[i].len, vecs[i].pen, vecs[i].par, vecs[i].msb, vecs[i].spb,
                vecs[i].rxeie, vecs[i].brkie);
      send_frame(vecs[i].data, int'(vecs[i].len), vecs[i].msb, vecs[i].pen, vecs[i].pbit,
                 vecs[i].stop1, vecs[i].spb, vecs[i].stop2);
      settle();
      chk($sformatf("v%0d_level", i), rd_if.level, vecs[i].lvl);
      chk($sformatf("v%0d_rdValid", i), rd_if.rdValid, vecs[i].lvl != 0);
      chk($sformatf("v%0d_rdData", i), rd_if.rdData, vecs[i].exp_d);
      chk($sformatf("v%0d_stPE", i), rd_if.stPE, vecs[i].pe);
      chk($sformatf("v%0d_stFE", i), rd_if.stFE, vecs[i].fe);
      chk($sformatf("v%0d_stOE", i), rd_if.stOE, 0);
      chk($sformatf("v%0d_stBRK", i), rd_if.stBRK, vecs[i].brk);
      chk($sformatf("v%0d_rxErr", i), rd_if.rxErr, vecs[i].pe | vecs[i].fe);
      chk($sformatf("v%0d_rxBusy", i), rxBusy, 0);
      rd_if.clrErr = 1'b1;
      settle();
      rd_if.clrErr = 1'b0;
      chk($sformatf("v%0d_clr_flags", i),
          {rd_if.stPE, rd_if.stFE, rd_if.stOE, rd_if.stBRK, rd_if.rxErr}, 0);
      if (vecs[i].lvl != 0) begin
        pop_chk($sformatf("v%0d_pop", i), vecs[i].exp_d, 3'd0);
        chk($sformatf("v%0d_empty_after_pop", i), rd_if.rdValid, 0);
      end
    end

    // Overrun: five frames without pops
    apply_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      send_frame(9'h011 + 9'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("ovf_level", rd_if.level, 4);
    chk("ovf_stOE", rd_if.stOE, 1);
    chk("ovf_rxErr", rd_if.rxErr, 1);
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("ovf_rd%0d", i), 9'h011 + 9'(i), 3'(3 - i));
    chk("ovf_drained", rd_if.rdValid, 0);

    // Same, popping in the fifth frame's DONE cycle
    apply_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      send_frame(9'h011 + 9'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fork
      send_frame(9'h015, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      pop_in_done(9);
    join
    settle();
    chk("donepop_level", rd_if.level, 4);
    chk("donepop_stOE", rd_if.stOE, 0);
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("donepop_rd%0d", i), 9'h012 + 9'(i), 3'(3 - i));

    // Start-detect latency and false start
    apply_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 Rx = 1'b0;
    settle();
    chk("fs_busy_1clk", rxBusy, 0);
    settle();
    chk("fs_busy_2clk", rxBusy, 0);
    settle();
    chk("fs_busy_3clk", rxBusy, 1);
    repeat (9) @(posedge MCLK);
    #1 Rx = 1'b1;
    repeat (2 * BIT_CYC) @(posedge MCLK);
    #1 chk_idle_outputs("false_start");

    // Asynchronous reset mid-DATA flushes the FIFO and the partial frame
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("prerst_level", rd_if.level, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    #1 Rx = 1'b0;
    repeat (20) @(posedge MCLK);
    #1 chk("prerst_busy", rxBusy, 1);
    reset_n = 1'b0;
    Rx = 1'b1;
    #2 chk_idle_outputs("midrst");
    repeat (3) @(posedge MCLK);
    #1 reset_n = 1'b1;
    repeat (BIT_CYC) @(posedge MCLK);
    #1 chk_idle_outputs("postrst");
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("postrst_level", rd_if.level, 1);
    chk("postrst_flags", {rd_if.stPE, rd_if.stFE, rd_if.stOE, rd_if.stBRK}, 0);
    pop_chk("postrst_pop", 9'h05A, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
